// File: rtl/hazard_ctrl.sv
// D-stage hazard unit: tracks in-flight destinations in E/M/W, decides stalls, picks
// forwarding sources for D and E operands, and blocks HI/LO users while mult/div runs.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_hilo_use,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    localparam logic [CNT_W-1:0] MULT_LEN = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LEN  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       TUSE_NONE = 2'd3;

    logic [4:0]       e_a3;
    logic [1:0]       e_tnew;
    logic [4:0]       e_rs;
    logic [4:0]       e_rt;
    logic [4:0]       m_a3;
    logic [1:0]       m_tnew;
    logic [4:0]       w_a3;
    logic [CNT_W-1:0] md_cnt;

    logic             stall_rs;
    logic             stall_rt;
    logic             md_load;

    // Nearest matching stage decides both the stall and the D-stage source, even when
    // that stage is not ready yet: an older copy of the register would be stale.
    function automatic logic [2:0] resolve_d(input logic [4:0] r, input logic [1:0] u);
        logic       hit_e;
        logic       hit_m;
        logic       hit_w;
        logic       stl;
        logic [1:0] sel;
        hit_e = (r != 5'd0) && (e_a3 == r);
        hit_m = (r != 5'd0) && (m_a3 == r);
        hit_w = (r != 5'd0) && (w_a3 == r);
        stl   = 1'b0;
        sel   = 2'd0;
        if (u != TUSE_NONE) begin
            if (hit_e) begin
                stl = (u < e_tnew);
                sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
            end else if (hit_m) begin
                stl = (u < m_tnew);
                sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
            end else if (hit_w) begin
                sel = 2'd3;
            end
        end
        return {stl, sel};
    endfunction

    function automatic logic [1:0] resolve_e(input logic [4:0] r);
        logic [1:0] sel;
        sel = 2'd0;
        if ((r != 5'd0) && (m_a3 == r)) begin
            sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        end else if ((r != 5'd0) && (w_a3 == r)) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        {stall_rs, fwd_d_rs} = resolve_d(d_rs, d_tuse_rs);
        {stall_rt, fwd_d_rt} = resolve_d(d_rt, d_tuse_rt);
        fwd_e_rs = resolve_e(e_rs);
        fwd_e_rt = resolve_e(e_rt);
        md_busy  = (md_cnt != '0);
        stall    = stall_rs | stall_rt | (d_hilo_use & md_busy);
        md_load  = d_md_start & ~stall;
    end

    // M and W keep draining during a stall; only E takes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_a3   <= 5'd0;
            e_tnew <= 2'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            m_a3   <= 5'd0;
            m_tnew <= 2'd0;
            w_a3   <= 5'd0;
            md_cnt <= '0;
        end else begin
            if (stall) begin
                e_a3   <= 5'd0;
                e_tnew <= 2'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
            end else begin
                e_a3   <= d_a3;
                e_tnew <= d_tnew;
                e_rs   <= d_rs;
                e_rt   <= d_rt;
            end
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_a3   <= m_a3;
            if (md_load) begin
                md_cnt <= d_md_div ? DIV_LEN : MULT_LEN;
            end else if (md_busy) begin
                md_cnt <= md_cnt - CNT_ONE;
            end
        end
    end

endmodule
